// File: rtl/uart_rx_if.sv
// Receive-side handshake bundle: received word with valid/ready, plus the
// single-cycle framing-error and overrun flags.
interface uart_rx_if #(
  parameter int N_DATA_BITS = 8
);
  logic [N_DATA_BITS-1:0] o_uart_data;
  logic                   o_uart_data_valid;
  logic                   i_uart_ready;
  logic                   o_uart_frame_err;
  logic                   o_uart_overrun;

  modport master (
    output o_uart_data,
    output o_uart_data_valid,
    output o_uart_frame_err,
    output o_uart_overrun,
    input  i_uart_ready
  );

  modport slave (
    input  o_uart_data,
    input  o_uart_data_valid,
    input  o_uart_frame_err,
    input  o_uart_overrun,
    output i_uart_ready
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop line synchroniser, centre-sampling bit
// FSM driven by an OVERSAMPLE x baud tick, valid/ready output with error flags.
module uart_rx #(
  parameter int N_DATA_BITS = 8,
  parameter int OVERSAMPLE  = 16
) (
  input  logic      i_uart_clk,
  input  logic      i_uart_reset,
  input  logic      i_uart_en,
  input  logic      i_uart_rx,
  uart_rx_if.master rx_if
);

  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int IDX_W = (N_DATA_BITS > 1) ? $clog2(N_DATA_BITS) : 1;

  localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic                   sync1_q;
  logic                   rx_s_q;
  state_t                 state_q,  state_d;
  logic [OS_W-1:0]        os_cnt_q, os_cnt_d;
  logic [IDX_W-1:0]       idx_q,    idx_d;
  logic [N_DATA_BITS-1:0] shift_q,  shift_d;
  logic [N_DATA_BITS-1:0] data_q,   data_d;
  logic                   valid_q,  valid_d;
  logic                   ferr_q,   ferr_d;
  logic                   ovr_q,    ovr_d;

  always_comb begin
    state_d  = state_q;
    os_cnt_d = os_cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = valid_q;
    ferr_d   = 1'b0;
    ovr_d    = 1'b0;

    if (valid_q && rx_if.i_uart_ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          os_cnt_d = '0;
          state_d  = S_START;
        end
      end

      S_START: begin
        if (i_uart_en) begin
          if (os_cnt_q == OS_HALF) begin
            if (rx_s_q) begin
              state_d = S_IDLE;
            end else begin
              os_cnt_d = '0;
              idx_d    = '0;
              state_d  = S_DATA;
            end
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end

      S_DATA: begin
        if (i_uart_en) begin
          if (os_cnt_q == OS_LAST) begin
            // LSB arrives first, so shift right and insert at the top.
            shift_d                  = shift_q >> 1;
            shift_d[N_DATA_BITS-1]   = rx_s_q;
            os_cnt_d                 = '0;
            idx_d                    = idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
              state_d = S_STOP;
            end
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end

      S_STOP: begin
        if (i_uart_en) begin
          if (os_cnt_q == OS_LAST) begin
            if (rx_s_q) begin
              state_d = S_IDLE;
              // A handshake in this same cycle frees the slot for the new word.
              if (valid_q && !rx_if.i_uart_ready) begin
                ovr_d = 1'b1;
              end else begin
                data_d  = shift_q;
                valid_d = 1'b1;
              end
            end else begin
              ferr_d  = 1'b1;
              state_d = S_BREAK;
            end
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end

      S_BREAK: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_uart_clk or negedge i_uart_reset) begin
    if (!i_uart_reset) begin
      sync1_q  <= 1'b1;
      rx_s_q   <= 1'b1;
      state_q  <= S_IDLE;
      os_cnt_q <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      sync1_q  <= i_uart_rx;
      rx_s_q   <= sync1_q;
      state_q  <= state_d;
      os_cnt_q <= os_cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  assign rx_if.o_uart_data       = data_q;
  assign rx_if.o_uart_data_valid = valid_q;
  assign rx_if.o_uart_frame_err  = ferr_q;
  assign rx_if.o_uart_overrun    = ovr_q;

endmodule
